mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store sequencer between the MEM pipeline stage and the data-memory port. It accepts one load or store per instruction and checks natural alignment. It drives a req/gnt/rvalid handshake to data memory with byte-lane alignment and byte enables, and stalls the pipeline until the access completes. Load data is lane-shifted and sign- or zero-extended to 64 bits before it returns to the pipeline.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage holds a memory instruction; held stable while stall=1.
- req_we  in  1  1=store, 0=load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data, right-aligned.
- req_unit  in  2  access size: 0=B, 1=HW, 2=W, 3=DW.
- req_ext  in  1  1=signed load, 0=unsigned; ignored for stores and DW.
- stall  out  1  freeze the pipeline.
- misalign  out  1  address not naturally aligned; no access issued.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  64  extended load data; stores leave it unchanged.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write strobe.
- dmem_addr  out  ADDR_W  req_addr with bits [2:0] cleared.
- dmem_wdata  out  64  lane-replicated store data.
- dmem_be  out  8  byte enables; 0 for loads.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  dmem_rdata valid.
- dmem_rdata  in  64  full aligned doubleword.

## Operation
- State machine: IDLE, REQ, WAIT, DONE. Reset forces IDLE.
- Alignment check: off=req_addr[2:0]. Misaligned when HW and off[0]!=0, W and off[1:0]!=0, or DW and off!=0.
- IDLE, req_valid=1, aligned:
  - latch we/addr/wdata/unit/ext;
  - stall=1 combinationally;
  - next state REQ.
- IDLE, req_valid=1, misaligned:
  - misalign=1 combinationally, stall=0;
  - no memory access; stay in IDLE.
- REQ: dmem_req=1 with the latched fields, held until dmem_gnt.
  - On gnt, store: next state DONE.
  - On gnt, load: next state WAIT.
- WAIT: on dmem_rvalid, register the extended load data into rsp_data; next state DONE.
- DONE: rsp_valid=1, stall=0, req_valid ignored; next state IDLE.
- stall=1 in REQ and WAIT.
- Byte enables (from latched off): B: 8'h01<<off; HW: 8'h03<<off; W: 8'h0F<<off; DW: 8'hFF.
- Store data lanes: B replicates wdata[7:0] ×8; HW replicates [15:0] ×4; W replicates [31:0] ×2; DW passes through.
- Load extraction: s = dmem_rdata >> (8*off).
  - Signed: B/HW/W are sign-extended from bit 7/15/31.
  - Unsigned: B/HW/W are zero-extended.
  - DW: s is returned unchanged, regardless of ext.
- dmem_rvalid outside WAIT is ignored.
- dmem_gnt while dmem_req=0 is ignored.

## Timing
- Reset values: stall=0, misalign=0, rsp_valid=0, rsp_data=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, dmem_be=0.
- dmem_rvalid arrives no earlier than the cycle after gnt.
- Minimum load latency, with gnt in the first REQ cycle and rvalid in the first WAIT cycle: accept in cycle 0, REQ in cycle 1, WAIT in cycle 2, rsp_valid in cycle 3. Stall is high for cycles 0–2.
- Minimum store latency: accept in cycle 0, REQ+gnt in cycle 1, rsp_valid in cycle 2.
- Every cycle without gnt adds one REQ cycle. Every cycle without rvalid adds one WAIT cycle. There is no timeout.
- Request outputs (dmem_*) are registered. They are stable throughout REQ and deasserted in the cycle after gnt.
- One outstanding access at most. A new request is accepted no earlier than the cycle after DONE.
- rst asserted in any state: all outputs take reset values after the edge and the pending access is dropped. An rvalid arriving after reset is ignored.

## Test plan
- Signed byte load, addr=0x1003, rdata=0x0000_0000_8000_0000, gnt immediate, rvalid next cycle -> dmem_addr=0x1000, be=0x00; rsp_valid in cycle 3 with rsp_data=0xFFFF_FFFF_FFFF_FF80; stall high for cycles 0–2.
- Unsigned halfword load, addr=0x2006, rdata=0xBEEF_0000_0000_0000 -> rsp_data=0x0000_0000_0000_BEEF.
- Word store, addr=0x3004, wdata=0x1234_5678, gnt withheld 3 cycles -> dmem_req high for 4 cycles, be=0xF0, dmem_wdata=0x1234_5678_1234_5678, rsp_valid 1 cycle after gnt.
- Misaligned word load at addr=0x4002 -> misalign=1 in the same cycle, stall=0, dmem_req never asserted.
- Signed DW load at addr=0x5000, rdata=0x8000_0000_0000_0001 -> rsp_data unchanged.
- rst during WAIT, then rvalid asserted -> state IDLE, stall=0, no rsp_valid, rsp_data=0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and the data-memory port.
// Checks natural alignment, drives req/gnt/rvalid, lane-aligns stores and extends loads.
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [1:0]        req_unit,
    input  logic              req_ext,
    output logic              stall,
    output logic              misalign,
    output logic              rsp_valid,
    output logic [63:0]       rsp_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [63:0]       dmem_wdata,
    output logic [7:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [63:0]       dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic        lat_we;
    logic [2:0]  lat_off;
    logic [1:0]  lat_unit;
    logic        lat_ext;
    logic        misaligned;

    function automatic logic [63:0] store_lanes(input logic [63:0] w, input logic [1:0] unit);
        case (unit)
            2'd0:    store_lanes = {8{w[7:0]}};
            2'd1:    store_lanes = {4{w[15:0]}};
            2'd2:    store_lanes = {2{w[31:0]}};
            default: store_lanes = w;
        endcase
    endfunction

    function automatic logic [7:0] byte_en(input logic [1:0] unit, input logic [2:0] off);
        case (unit)
            2'd0:    byte_en = 8'h01 << off;
            2'd1:    byte_en = 8'h03 << off;
            2'd2:    byte_en = 8'h0F << off;
            default: byte_en = 8'hFF;
        endcase
    endfunction

    // Shift the addressed lane down to bit 0, then extend to 64 bits; DW ignores ext.
    function automatic logic [63:0] load_ext(input logic [63:0] rdata, input logic [2:0] off,
                                             input logic [1:0] unit, input logic ext);
        logic [63:0] s;
        s = rdata >> {off, 3'b000};
        case (unit)
            2'd0:    load_ext = ext ? {{56{s[7]}}, s[7:0]}   : {56'd0, s[7:0]};
            2'd1:    load_ext = ext ? {{48{s[15]}}, s[15:0]} : {48'd0, s[15:0]};
            2'd2:    load_ext = ext ? {{32{s[31]}}, s[31:0]} : {32'd0, s[31:0]};
            default: load_ext = s;
        endcase
    endfunction

    // Natural-alignment check on the incoming address.
    always_comb begin
        misaligned = 1'b0;
        case (req_unit)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign stall    = ((state == IDLE) && req_valid && !misaligned) || (state == REQ) || (state == WAIT);
    assign misalign = (state == IDLE) && req_valid && misaligned;

    // Sequencer state, latched request fields and registered memory/response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_off    <= 3'd0;
            lat_unit   <= 2'd0;
            lat_ext    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= 64'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= 64'd0;
            dmem_be    <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && !misaligned) begin
                        lat_we     <= req_we;
                        lat_off    <= req_addr[2:0];
                        lat_unit   <= req_unit;
                        lat_ext    <= req_ext;
                        dmem_req   <= 1'b1;
                        dmem_we    <= req_we;
                        dmem_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
                        dmem_wdata <= store_lanes(req_wdata, req_unit);
                        dmem_be    <= req_we ? byte_en(req_unit, req_addr[2:0]) : 8'h00;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        dmem_be  <= 8'h00;
                        if (lat_we) begin
                            rsp_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rvalid) begin
                        rsp_data  <= load_ext(dmem_rdata, lat_off, lat_unit, lat_ext);
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table of full transactions plus
// hand-written reset-in-WAIT and stray-handshake sequences.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_unit;
    logic        req_ext;
    logic        stall;
    logic        misalign;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [63:0] dmem_rdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_unit   (req_unit),
        .req_ext    (req_ext),
        .stall      (stall),
        .misalign   (misalign),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [1:0]  unit;
        logic        ext;
        logic [63:0] rdata;
        int          gnt_wait;
        int          rv_wait;
        logic        exp_mis;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rsp;
    } vec_t;

    localparam int NVEC = 14;
    vec_t        vecs [NVEC];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_rsp_data = 64'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_unit  = v.unit;
        req_ext   = v.ext;
        #1;
        if (v.exp_mis) begin
            chk($sformatf("v%0d misalign", idx), {63'd0, misalign}, 64'd1);
            chk($sformatf("v%0d mis_stall", idx), {63'd0, stall}, 64'd0);
            tick;
            chk($sformatf("v%0d mis_no_req", idx), {63'd0, dmem_req}, 64'd0);
            req_valid = 1'b0;
            #1;
            chk($sformatf("v%0d mis_clear", idx), {63'd0, misalign}, 64'd0);
        end else begin
            chk($sformatf("v%0d accept_stall", idx), {63'd0, stall}, 64'd1);
            chk($sformatf("v%0d accept_mis", idx), {63'd0, misalign}, 64'd0);
            tick;
            for (int k = 0; k <= v.gnt_wait; k++) begin
                chk($sformatf("v%0d req_%0d", idx, k), {63'd0, dmem_req}, 64'd1);
                chk($sformatf("v%0d req_stall", idx), {63'd0, stall}, 64'd1);
                chk($sformatf("v%0d addr", idx), {32'd0, dmem_addr}, {32'd0, v.addr[31:3], 3'b000});
                chk($sformatf("v%0d we", idx), {63'd0, dmem_we}, {63'd0, v.we});
                chk($sformatf("v%0d be", idx), {56'd0, dmem_be}, {56'd0, v.exp_be});
                if (v.we) chk($sformatf("v%0d wdata", idx), dmem_wdata, v.exp_wdata);
                // stray rvalid during REQ must be ignored
                dmem_rvalid = !v.we;
                dmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
                dmem_gnt    = (k == v.gnt_wait);
                tick;
                dmem_gnt    = 1'b0;
                dmem_rvalid = 1'b0;
            end
            chk($sformatf("v%0d req_drop", idx), {63'd0, dmem_req}, 64'd0);
            if (!v.we) begin
                for (int k = 0; k <= v.rv_wait; k++) begin
                    chk($sformatf("v%0d wait_stall", idx), {63'd0, stall}, 64'd1);
                    chk($sformatf("v%0d wait_rsp", idx), {63'd0, rsp_valid}, 64'd0);
                    dmem_rdata  = v.rdata;
                    dmem_rvalid = (k == v.rv_wait);
                    tick;
                    dmem_rvalid = 1'b0;
                end
                exp_rsp_data = v.exp_rsp;
            end
            chk($sformatf("v%0d rsp_valid", idx), {63'd0, rsp_valid}, 64'd1);
            chk($sformatf("v%0d done_stall", idx), {63'd0, stall}, 64'd0);
            chk($sformatf("v%0d rsp_data", idx), rsp_data, exp_rsp_data);
            req_valid = 1'b0;
            tick;
            chk($sformatf("v%0d rsp_pulse", idx), {63'd0, rsp_valid}, 64'd0);
            chk($sformatf("v%0d idle_req", idx), {63'd0, dmem_req}, 64'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 32'h0000_1003, 64'h0, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 0, 0, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[1]  = '{1'b0, 32'h0000_2006, 64'h0, 2'd1, 1'b0, 64'hBEEF_0000_0000_0000, 0, 0, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_BEEF};
        vecs[2]  = '{1'b0, 32'h0000_5000, 64'h0, 2'd3, 1'b1, 64'h8000_0000_0000_0001, 1, 2, 1'b0, 8'h00, 64'h0, 64'h8000_0000_0000_0001};
        vecs[3]  = '{1'b0, 32'h0000_6004, 64'h0, 2'd2, 1'b1, 64'h8765_4321_0000_0000, 0, 0, 1'b0, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321};
        vecs[4]  = '{1'b0, 32'h0000_7005, 64'h0, 2'd0, 1'b0, 64'h0000_9A00_0000_0000, 0, 1, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_009A};
        vecs[5]  = '{1'b0, 32'h0000_8002, 64'h0, 2'd1, 1'b1, 64'h0000_0000_7FFF_0000, 2, 0, 1'b0, 8'h00, 64'h0, 64'h0000_0000_0000_7FFF};
        vecs[6]  = '{1'b1, 32'h0000_3004, 64'h0000_0000_1234_5678, 2'd2, 1'b0, 64'h0, 3, 0, 1'b0, 8'hF0, 64'h1234_5678_1234_5678, 64'h0};
        vecs[7]  = '{1'b1, 32'h0000_9005, 64'h0000_0000_0000_00AB, 2'd0, 1'b1, 64'h0, 0, 0, 1'b0, 8'h20, 64'hABAB_ABAB_ABAB_ABAB, 64'h0};
        vecs[8]  = '{1'b1, 32'h0000_A002, 64'hFFFF_FFFF_FFFF_CDEF, 2'd1, 1'b0, 64'h0, 1, 0, 1'b0, 8'h0C, 64'hCDEF_CDEF_CDEF_CDEF, 64'h0};
        vecs[9]  = '{1'b1, 32'h0000_B000, 64'h0123_4567_89AB_CDEF, 2'd3, 1'b0, 64'h0, 0, 0, 1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0};
        vecs[10] = '{1'b0, 32'h0000_4002, 64'h0, 2'd2, 1'b0, 64'h0, 0, 0, 1'b1, 8'h00, 64'h0, 64'h0};
        vecs[11] = '{1'b0, 32'h0000_4001, 64'h0, 2'd1, 1'b1, 64'h0, 0, 0, 1'b1, 8'h00, 64'h0, 64'h0};
        vecs[12] = '{1'b1, 32'h0000_4004, 64'h0, 2'd3, 1'b0, 64'h0, 0, 0, 1'b1, 8'h00, 64'h0, 64'h0};
        vecs[13] = '{1'b0, 32'h0000_C000, 64'h0, 2'd2, 1'b0, 64'hFFFF_FFFF_8000_0000, 0, 0, 1'b0, 8'h00, 64'h0, 64'h0000_0000_8000_0000};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 64'd0;
        req_unit = 2'd0; req_ext = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 64'd0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_misalign", {63'd0, misalign}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
        chk("rst_dmem_we", {63'd0, dmem_we}, 64'd0);
        chk("rst_dmem_addr", {32'd0, dmem_addr}, 64'd0);
        chk("rst_dmem_wdata", dmem_wdata, 64'd0);
        chk("rst_dmem_be", {56'd0, dmem_be}, 64'd0);

        // gnt and rvalid while idle must not start anything
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 64'h1111_2222_3333_4444;
        tick;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk("idle_gnt_req", {63'd0, dmem_req}, 64'd0);
        chk("idle_rv_rsp", {63'd0, rsp_valid}, 64'd0);
        chk("idle_rv_data", rsp_data, 64'd0);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // reset while in WAIT drops the access; later rvalid is ignored
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_1003; req_unit = 2'd0; req_ext = 1'b1;
        tick;
        dmem_gnt = 1'b1;
        tick;
        dmem_gnt = 1'b0;
        req_valid = 1'b0;
        chk("rstw_in_wait", {63'd0, stall}, 64'd1);
        chk("rstw_prev_data", rsp_data, 64'h0000_0000_8000_0000);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rstw_stall", {63'd0, stall}, 64'd0);
        chk("rstw_rsp_data", rsp_data, 64'd0);
        chk("rstw_req", {63'd0, dmem_req}, 64'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 64'h0000_0000_8000_0000;
        tick;
        dmem_rvalid = 1'b0;
        chk("rstw_late_rv", {63'd0, rsp_valid}, 64'd0);
        chk("rstw_late_data", rsp_data, 64'd0);
        chk("rstw_late_stall", {63'd0, stall}, 64'd0);
        tick;
        chk("rstw_no_rsp", {63'd0, rsp_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
